// File: rtl/frodo_sampler_pkg.sv
// Shared definitions for the FrodoKEM error sampler:
// CDF table, sample widths and FSM encoding.
package frodo_sampler_pkg;

  localparam int SMP_W = 4;
  localparam int MAG_W = 3;
  localparam int CDF_N = 6;

  // Index 0 is the smallest threshold.
  localparam logic [CDF_N-1:0][14:0] CDF_TBL = {
    15'd32765, 15'd32725, 15'd32361,
    15'd30338, 15'd23462, 15'd9142
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/frodo_sampler_cdf.sv
// Combinational word-to-sample map: magnitude is the
// number of CDF entries below r, sign dropped for zero.
module frodoCdfSample
  import frodo_sampler_pkg::*;
(
  input  logic [15:0]      i_word,
  output logic [SMP_W-1:0] o_smp
);

  logic [MAG_W-1:0] w_mag;

  // Strict-compare count against every CDF threshold.
  always_comb begin
    w_mag = '0;
    for (int i = 0; i < CDF_N; i++) begin
      if (CDF_TBL[i] < i_word[15:1]) begin
        w_mag = w_mag + 1'b1;
      end
    end
  end

  assign o_smp = {(w_mag != '0) & i_word[0], w_mag};

endmodule

// File: rtl/frodo_sampler.sv
// Packs CDF samples into S-lane vectors behind a
// one-entry output register with valid/ready handshakes.
module frodo_sampler
  import frodo_sampler_pkg::*;
#(
  parameter int S = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      numVec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*S-1:0]   out_data,
  output logic             busy,
  output logic             done
);

  localparam int LW = (S > 1) ? $clog2(S) : 1;
  localparam logic [LW-1:0] LAST = LW'(S - 1);

  state_t           r_state;
  state_t           w_next;
  logic [LW-1:0]    r_lane;
  logic [20:0]      r_left;
  logic [4*S-1:0]   r_pack;
  logic [4*S-1:0]   r_out;
  logic             r_ovalid;

  logic [SMP_W-1:0] w_smp;
  logic [4*S-1:0]   w_vec;
  logic             w_last;
  logic             w_fire;
  logic             w_drain;
  logic             w_start;
  logic             w_done;

  frodoCdfSample u_cdf (
    .i_word (in_data),
    .o_smp  (w_smp)
  );

  assign w_last  = (r_lane == LAST);
  assign w_drain = r_ovalid && out_ready;
  assign w_start = (r_state == ST_IDLE) && start;

  // Only the vector-completing word waits on the output.
  assign in_ready = (r_state == ST_RUN) &&
                    (r_left != '0) &&
                    (!w_last || !r_ovalid || out_ready);
  assign w_fire   = in_valid && in_ready;

  assign out_valid = r_ovalid;
  assign out_data  = r_out;
  assign busy      = (r_state != ST_IDLE);
  assign done      = w_done;

  // Pack register with the incoming sample merged in.
  always_comb begin
    w_vec = r_pack;
    w_vec[4*r_lane +: 4] = w_smp;
  end

  // Next-state and done pulse.
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (numVec == 16'd0) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_fire && r_left == 21'd1) begin
          w_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!r_ovalid || out_ready) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Lane and word counters plus the pack register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= '0;
      r_left <= '0;
      r_pack <= '0;
    end else if (w_start) begin
      r_lane <= '0;
      r_left <= 21'(numVec) * 21'(S);
    end else if (w_fire) begin
      r_lane <= w_last ? '0 : r_lane + 1'b1;
      r_left <= r_left - 21'd1;
      r_pack <= w_vec;
    end
  end

  // Output register: load wins over drain, so both at once is lossless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out    <= '0;
      r_ovalid <= 1'b0;
    end else if (w_fire && w_last) begin
      r_out    <= w_vec;
      r_ovalid <= 1'b1;
    end else if (w_drain) begin
      r_ovalid <= 1'b0;
    end
  end

endmodule
